// File: rtl/score_keeper.sv
// score_keeper: two-digit BCD score with combo multiplier and saturation; idle/play/done sequencing for the score display
module score_keeper #(
  parameter int unsigned PERFECT_PTS  = 2,
  parameter int unsigned GOOD_PTS     = 1,
  parameter int unsigned COMBO_THRESH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       songDone,
  input  logic       hitPerfect,
  input  logic       hitGood,
  input  logic       miss,
  output logic [8:0] score,
  output logic [3:0] combo,
  output logic       multActive,
  output logic       gameOver
);
  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
  state_t     state_q, state_d;
  logic [8:0] score_q, score_d;
  logic [3:0] combo_q, combo_d;
  logic       mult_q, mult_d;
  logic       go_q, go_d;
  logic [3:0] base, pts;
  logic [4:0] ones_sum, ones_n, tens_n;
  logic       carry, sat;
  always_comb begin
    base     = hitPerfect ? 4'(PERFECT_PTS) : 4'(GOOD_PTS);
    pts      = mult_q ? {base[2:0], 1'b0} : base;
    ones_sum = {1'b0, score_q[3:0]} + {1'b0, pts};
    carry    = ones_sum > 5'd9;
    ones_n   = carry ? ones_sum - 5'd10 : ones_sum;
    tens_n   = {1'b0, score_q[7:4]} + {4'b0, carry};
    sat      = tens_n > 5'd9;
    state_d  = state_q;
    score_d  = score_q;
    combo_d  = combo_q;
    if (start) begin
      state_d = PLAY;
      score_d = '0;
      combo_d = '0;
    end else if (state_q == PLAY) begin
      if (hitPerfect || hitGood) begin
        combo_d = (combo_q == 4'hf) ? combo_q : combo_q + 4'd1;
        score_d = score_q[8] ? score_q : sat ? 9'h199 : {1'b0, tens_n[3:0], ones_n[3:0]};
      end else if (miss) begin
        combo_d = '0;
      end
      if (songDone) state_d = DONE;
    end
    mult_d = combo_d >= 4'(COMBO_THRESH);
    go_d   = state_d == DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      score_q <= '0;
      combo_q <= '0;
      mult_q  <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      combo_q <= combo_d;
      mult_q  <= mult_d;
      go_q    <= go_d;
    end
  end
  assign score      = score_q;
  assign combo      = combo_q;
  assign multActive = mult_q;
  assign gameOver   = go_q;
endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Game-logic stage directly upstream of the two-digit seven-segment score display.
- Consumes per-step judgement pulses from the arrow-timing judge and keeps the running score as two BCD digits plus a saturation flag.
- Tracks a hit combo that doubles points once the player holds a streak.
- Sequences idle / playing / game-over so the display holds the final score after the song ends.

Parameters:
- PERFECT_PTS, 2, base points for a perfect hit (1..4)
- GOOD_PTS, 1, base points for a good hit (1..4)
- COMBO_THRESH, 4, combo count at or above which points are doubled (1..15)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse: begin or restart a song
- songDone  input  1  one-cycle pulse: song finished
- hitPerfect  input  1  one-cycle pulse: perfect judgement
- hitGood  input  1  one-cycle pulse: good judgement
- miss  input  1  one-cycle pulse: missed arrow
- score  output  9  [7:4] tens BCD, [3:0] ones BCD, [8] saturated flag
- combo  output  4  current consecutive-hit count, saturating
- multActive  output  1  high when combo >= COMBO_THRESH
- gameOver  output  1  high in DONE state

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, score=9'h000, combo=0, multActive=0, gameOver=0.
- State IDLE:
  - All judgement inputs are ignored.
  - start -> clear score and combo, go to PLAY.
- State PLAY:
  - Judgements are applied as described below.
  - songDone -> DONE.
  - start -> clear score and combo, stay in PLAY. start has priority over songDone and over judgements in the same cycle.
- State DONE:
  - gameOver=1. score and combo are frozen, and judgements are ignored.
  - start -> clear, go to PLAY.
- Judgement priority, for one event per cycle: perfect > good > miss. Lower-priority pulses in the same cycle are dropped.
  - songDone in the same cycle as a judgement: the judgement is applied first, then the block enters DONE.
- Points:
  - pts = PERFECT_PTS or GOOD_PTS.
  - pts is doubled if multActive, i.e. combo >= COMBO_THRESH evaluated on the pre-update combo value. Maximum add is 8.
- Combo:
  - A hit increments combo, saturating at 15.
  - A miss clears combo to 0 and adds no points.
- BCD add:
  - ones + pts; if the result > 9, subtract 10 and carry into tens.
  - If tens would exceed 9, score saturates to 99 (score[7:0]=8'h99) and score[8] is set.
  - score[8] stays set until start or reset.
  - Once saturated, further hits change only combo.
- Latency: all outputs are registered. A judgement in cycle N is visible in score, combo and multActive in cycle N+1.
- Display compatibility: score[7:0] digits are always valid BCD (0..9).
- Reset mid-song returns immediately to IDLE with cleared outputs.

Test Plan:
- Reset, then start, then 3 hitGood on separate cycles -> score=9'h003, combo=3, multActive=0. Each update lands exactly one cycle after its pulse.
- From reset, start, then 4 hitPerfect -> score 02,04,06,08. A 5th hitPerfect (combo=4, multActive=1) -> score 9'h012, combo=5.
- In PLAY with combo=6, miss -> combo=0, multActive=0, score unchanged. Next hitGood adds 1, not 2.
- Preload to 97 with combo>=4, then hitPerfect (+4) -> score=9'h199. A further hitGood leaves score=9'h199 while combo increments.
- hitPerfect+hitGood+miss in the same cycle -> only +PERFECT_PTS applied, combo+1. songDone with hitGood in the same cycle -> point added, gameOver=1 next cycle. Later hits are ignored.
- Assert reset asynchronously mid-song (score=9'h045) -> outputs clear without waiting for a clk edge. In DONE, start -> score=9'h000, gameOver=0, state PLAY.
